// File: rtl/usb_rx_pkg.sv
// Shared constants, state encoding and the CRC16 byte step for the USB RX packet parser.
// The optional CRC16 residual check is built when USB_RX_CRC16_CHECK_EN is defined.
package usb_rx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h01;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  typedef enum logic [2:0] {
    IDLE,
    PID,
    HSHK,
    TOKEN,
    DATA,
    DONE,
    ERR
  } rx_state_t;

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC16_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_rx_packet_parser_crc16.sv
// Byte-wide reflected CRC16 accumulator with synchronous clear and enable.
// Only instantiated when USB_RX_CRC16_CHECK_EN is defined.
module usb_rx_crc16
  import usb_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      crc <= CRC16_INIT;
    else if (clr) crc <= CRC16_INIT;
    else if (en)  crc <= crc16_byte(crc, data_in);
  end

endmodule

// File: rtl/usb_rx_packet_parser.sv
// USB RX packet parser: splits decoded bytes into SYNC/PID/payload/CRC fields.
// Define USB_RX_CRC16_CHECK_EN to check the DATA-packet CRC16 residual at eop.
module usb_rx_packet_parser
  import usb_rx_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 64,
  parameter int FIFO_DEPTH     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  input  logic       eop,
  input  logic       stuff_err,
  input  logic [6:0] buffer_occupancy,
  output logic       store_rx_data,
  output logic [7:0] rx_data,
  output logic [3:0] rx_pid,
  output logic       pid_valid,
  output logic [6:0] token_addr,
  output logic [3:0] token_endp,
  output logic [6:0] data_count,
  output logic       packet_done,
  output logic       rx_error
);

  localparam logic [6:0] FIFO_FULL = 7'(FIFO_DEPTH);
  localparam logic [6:0] MAX_CNT   = 7'(MAX_DATA_BYTES);

  rx_state_t  state, state_nx;
  logic [7:0] hold_new, hold_old;
  logic [1:0] hcnt;
  logic [1:0] tcnt;
  logic       b0_msb;

  logic       pid_ok, is_hshk, is_tok, is_data;
  logic       sync_hit, byte_ok;
  logic       push_try, push_full, push_ovf, push_ok;
  logic       crc_ok;

  assign pid_ok  = byte_in[7:4] == ~byte_in[3:0];
  assign is_hshk = byte_in[3:0] inside {PID_ACK, PID_NAK, PID_STALL};
  assign is_tok  = byte_in[3:0] inside {PID_OUT, PID_IN, PID_SETUP};
  assign is_data = byte_in[3:0] inside {PID_DATA0, PID_DATA1};

  assign sync_hit  = state == IDLE && byte_valid && byte_in == SYNC_BYTE;
  assign byte_ok   = byte_valid && !stuff_err;
  assign push_try  = state == DATA && byte_ok && hcnt == 2'd2;
  assign push_full = buffer_occupancy == FIFO_FULL;
  assign push_ovf  = data_count == MAX_CNT;
  assign push_ok   = push_try && !push_full && !push_ovf;

`ifdef USB_RX_CRC16_CHECK_EN
  logic [15:0] crc;

  usb_rx_crc16 u_crc (
    .clk     (clk),
    .rst     (rst),
    .clr     (sync_hit),
    .en      (state == DATA && byte_ok),
    .data_in (byte_in),
    .crc     (crc)
  );

  assign crc_ok = crc == CRC16_RESIDUAL;
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (sync_hit) state_nx = PID;
      PID: begin
        if (stuff_err || eop) begin
          state_nx = ERR;
        end else if (byte_valid) begin
          if (!pid_ok) begin
            state_nx = ERR;
          end else begin
            unique case (1'b1)
              is_hshk: state_nx = HSHK;
              is_tok:  state_nx = TOKEN;
              is_data: state_nx = DATA;
              default: state_nx = ERR;
            endcase
          end
        end
      end
      HSHK: begin
        if (stuff_err || byte_valid) state_nx = ERR;
        else if (eop)                state_nx = DONE;
      end
      TOKEN: begin
        if (stuff_err)                      state_nx = ERR;
        else if (byte_valid && tcnt == 2'd2) state_nx = ERR;
        else if (eop)
          state_nx = (tcnt == 2'd2) ? DONE : ERR;
      end
      DATA: begin
        if (stuff_err)                  state_nx = ERR;
        else if (push_try && !push_ok)  state_nx = ERR;
        else if (eop)
          state_nx = (hcnt == 2'd2 && crc_ok) ? DONE : ERR;
      end
      DONE: state_nx = stuff_err ? ERR : IDLE;
      ERR:  if (eop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: strobes are registered so they appear one cycle after the byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_rx_data <= 1'b0;
      rx_data       <= '0;
      rx_pid        <= '0;
      pid_valid     <= 1'b0;
      token_addr    <= '0;
      token_endp    <= '0;
      data_count    <= '0;
      packet_done   <= 1'b0;
      rx_error      <= 1'b0;
      hold_new      <= '0;
      hold_old      <= '0;
      hcnt          <= '0;
      tcnt          <= '0;
      b0_msb        <= 1'b0;
    end else begin
      store_rx_data <= 1'b0;
      pid_valid     <= 1'b0;
      packet_done   <= state_nx == DONE;
      if (state_nx == ERR) rx_error <= 1'b1;
      if (sync_hit) begin
        rx_error   <= 1'b0;
        data_count <= '0;
      end
      if (state == PID && state_nx inside {HSHK, TOKEN, DATA}) begin
        rx_pid    <= byte_in[3:0];
        pid_valid <= 1'b1;
        hcnt      <= '0;
        tcnt      <= '0;
      end
      if (state == TOKEN && byte_ok && tcnt != 2'd2) begin
        tcnt <= tcnt + 2'd1;
        if (tcnt == 2'd0) begin
          token_addr <= byte_in[6:0];
          b0_msb     <= byte_in[7];
        end else begin
          token_endp <= {byte_in[2:0], b0_msb};
        end
      end
      if (state == DATA && byte_ok) begin
        hold_new <= byte_in;
        hold_old <= hold_new;
        if (hcnt != 2'd2) hcnt <= hcnt + 2'd1;
        if (push_ok) begin
          store_rx_data <= 1'b1;
          rx_data       <= hold_old;
          data_count    <= data_count + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_packet_parser.sv
// Directed self-checking bench for usb_rx_packet_parser.
// Define USB_RX_CRC16_CHECK_EN to also exercise the CRC16 residual check.
module tb_usb_rx_packet_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = '0;
  logic       eop = 1'b0;
  logic       stuff_err = 1'b0;
  logic [6:0] buffer_occupancy = '0;
  logic       store_rx_data;
  logic [7:0] rx_data;
  logic [3:0] rx_pid;
  logic       pid_valid;
  logic [6:0] token_addr;
  logic [3:0] token_endp;
  logic [6:0] data_count;
  logic       packet_done;
  logic       rx_error;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pid = 0;
  int n_done = 0;
  logic [7:0] pushed[$];
  logic [7:0] pl[$];

  always #5 clk = ~clk;

  usb_rx_packet_parser dut (
    .clk              (clk),
    .rst              (rst),
    .byte_valid       (byte_valid),
    .byte_in          (byte_in),
    .eop              (eop),
    .stuff_err        (stuff_err),
    .buffer_occupancy (buffer_occupancy),
    .store_rx_data    (store_rx_data),
    .rx_data          (rx_data),
    .rx_pid           (rx_pid),
    .pid_valid        (pid_valid),
    .token_addr       (token_addr),
    .token_endp       (token_endp),
    .data_count       (data_count),
    .packet_done      (packet_done),
    .rx_error         (rx_error)
  );

  always @(negedge clk) begin
    if (store_rx_data) pushed.push_back(rx_data);
    if (pid_valid)     n_pid++;
    if (packet_done)   n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c,
                                          input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_mon();
    pushed.delete();
    n_pid = 0;
    n_done = 0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in = b;
    tick(1);
    byte_valid = 1'b0;
  endtask

  task automatic send_eop();
    eop = 1'b1;
    tick(1);
    eop = 1'b0;
    tick(3);
  endtask

  task automatic send_data(input logic [7:0] pidb, input logic [7:0] p[$],
                           input bit bad);
    logic [15:0] c;
    c = 16'hFFFF;
    clr_mon();
    send(8'h01);
    send(pidb);
    foreach (p[i]) begin
      send(p[i]);
      c = crc_upd(c, p[i]);
    end
    c = ~c;
    if (bad) c = c ^ 16'h0101;
    send(c[7:0]);
    send(c[15:8]);
    send_eop();
  endtask

  initial begin
    tick(3);
    check("rst_store", 32'(store_rx_data), 0);
    check("rst_pid", 32'(rx_pid), 0);
    check("rst_err", 32'(rx_error), 0);
    check("rst_cnt", 32'(data_count), 0);
    rst = 1'b0;
    tick(2);

    clr_mon();
    send(8'h01); send(8'hD2); send_eop();
    check("hs_pidv", 32'(n_pid), 1);
    check("hs_pid", 32'(rx_pid), 32'h2);
    check("hs_done", 32'(n_done), 1);
    check("hs_push", 32'(pushed.size()), 0);
    check("hs_err", 32'(rx_error), 0);

    pl.delete();
    pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    send_data(8'hC3, pl, 1'b0);
    check("d0_npush", 32'(pushed.size()), 3);
    check("d0_b0", 32'(pushed[0]), 32'h11);
    check("d0_b1", 32'(pushed[1]), 32'h22);
    check("d0_b2", 32'(pushed[2]), 32'h33);
    check("d0_cnt", 32'(data_count), 3);
    check("d0_done", 32'(n_done), 1);
    check("d0_pid", 32'(rx_pid), 32'h3);
    check("d0_err", 32'(rx_error), 0);

`ifdef USB_RX_CRC16_CHECK_EN
    send_data(8'hC3, pl, 1'b1);
    check("crc_done", 32'(n_done), 0);
    check("crc_err", 32'(rx_error), 1);
`endif

    pl.delete();
    send_data(8'hC3, pl, 1'b0);
    check("zl_done", 32'(n_done), 1);
    check("zl_cnt", 32'(data_count), 0);
    check("zl_push", 32'(pushed.size()), 0);

    clr_mon();
    send(8'h01); send(8'hD3); send_eop();
    check("bp_err", 32'(rx_error), 1);
    check("bp_pidv", 32'(n_pid), 0);
    check("bp_push", 32'(pushed.size()), 0);
    check("bp_done", 32'(n_done), 0);

    buffer_occupancy = 7'd64;
    pl.delete();
    pl.push_back(8'hAA); pl.push_back(8'hBB); pl.push_back(8'hCC);
    send_data(8'h4B, pl, 1'b0);
    check("ff_push", 32'(pushed.size()), 0);
    check("ff_err", 32'(rx_error), 1);
    check("ff_done", 32'(n_done), 0);
    check("ff_pid", 32'(rx_pid), 32'hB);
    buffer_occupancy = 7'd0;
    clr_mon();
    send(8'h01); send(8'h5A); send_eop();
    check("ff_idle_done", 32'(n_done), 1);
    check("ff_idle_err", 32'(rx_error), 0);
    check("ff_idle_pid", 32'(rx_pid), 32'hA);

    clr_mon();
    send(8'h01); send(8'h69); send(8'h85); send(8'h0B); send_eop();
    check("tk_pid", 32'(rx_pid), 32'h9);
    check("tk_addr", 32'(token_addr), 32'h05);
    check("tk_endp", 32'(token_endp), 32'h7);
    check("tk_done", 32'(n_done), 1);
    check("tk_err", 32'(rx_error), 0);

    clr_mon();
    send(8'h01); send(8'hE1); send(8'h85); send(8'h0B); send(8'h00);
    send_eop();
    check("tk3_err", 32'(rx_error), 1);
    check("tk3_done", 32'(n_done), 0);

    clr_mon();
    send(8'h01); send(8'h2D); send(8'h85); send_eop();
    check("tk1_err", 32'(rx_error), 1);
    check("tk1_done", 32'(n_done), 0);

    clr_mon();
    send(8'h01); send(8'hC3); send(8'h11); send_eop();
    check("dshort_err", 32'(rx_error), 1);
    check("dshort_done", 32'(n_done), 0);

    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    send_data(8'h4B, pl, 1'b0);
    check("max_push", 32'(pushed.size()), 64);
    check("max_last", 32'(pushed[63]), 32'h3F);
    check("max_cnt", 32'(data_count), 64);
    check("max_done", 32'(n_done), 1);
    check("max_err", 32'(rx_error), 0);

    pl.push_back(8'h40);
    send_data(8'h4B, pl, 1'b0);
    check("ovf_push", 32'(pushed.size()), 64);
    check("ovf_err", 32'(rx_error), 1);
    check("ovf_done", 32'(n_done), 0);

    clr_mon();
    send(8'h01); send(8'hC3); send(8'h11); send(8'h22); send(8'h33);
    stuff_err = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'h44;
    tick(1);
    stuff_err = 1'b0;
    byte_valid = 1'b0;
    tick(1);
    check("se_push", 32'(pushed.size()), 1);
    check("se_b0", 32'(pushed[0]), 32'h11);
    check("se_err", 32'(rx_error), 1);
    send_eop();
    send(8'h01);
    tick(1);
    check("se_clr", 32'(rx_error), 0);
    send(8'hD2); send_eop();
    check("se_next_done", 32'(n_done), 1);

    clr_mon();
    send(8'h01); send(8'hC3); send(8'h11); send(8'h22); send(8'h33);
    tick(1);
    check("mr_pre_cnt", 32'(data_count), 1);
    rst = 1'b1;
    #1;
    check("mr_store", 32'(store_rx_data), 0);
    check("mr_data", 32'(rx_data), 0);
    check("mr_pid", 32'(rx_pid), 0);
    check("mr_addr", 32'(token_addr), 0);
    check("mr_endp", 32'(token_endp), 0);
    check("mr_cnt", 32'(data_count), 0);
    check("mr_pidv", 32'(pid_valid), 0);
    check("mr_done", 32'(packet_done), 0);
    check("mr_err", 32'(rx_error), 0);
    @(negedge clk);
    rst = 1'b0;
    clr_mon();
    send(8'h44); send(8'h55); send(8'h66); tick(2);
    check("mr_nopush", 32'(pushed.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
